// File: rtl/mips_pkg.sv
// mips_pkg: shared encodings and helpers for the MIPS32 pipeline control blocks.
package mips_pkg;
  localparam logic [1:0] JMP_NONE = 2'b00;
  localparam logic [1:0] JMP_J    = 2'b01;
  localparam logic [1:0] JMP_JR   = 2'b10;
  localparam logic [1:0] FWD_RF   = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;
  typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} hz_state_e;
  function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic mem_we,
                                         input logic [4:0] mem_rd, input logic wb_we,
                                         input logic [4:0] wb_rd);
    return (mem_we && mem_rd != 5'd0 && mem_rd == src) ? FWD_MEM :
           (wb_we && wb_rd != 5'd0 && wb_rd == src)    ? FWD_WB  : FWD_RF;
  endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_o <= '0;
    else if (inc_i && !(&cnt_o)) cnt_o <= cnt_o + 1'b1;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forwarding control for the 5-stage pipe, with dmem
// freeze, timeout error state and saturating stall/flush counters.
module hazard_ctrl
  import mips_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [1:0]       id_jump,
  input  logic [4:0]       ex_rs,
  input  logic [4:0]       ex_rt,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_reg_write,
  input  logic             ex_branch_taken,
  input  logic [4:0]       mem_rd,
  input  logic             mem_reg_write,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic [4:0]       wb_rd,
  input  logic             wb_reg_write,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam int WW = $clog2(TIMEOUT + 1);
  hz_state_e     state_q;
  logic [WW-1:0] wait_q;
  logic          mem_err_q;
  logic          freeze, hold, jr_stall, load_use, stall, jump;
  assign freeze   = dmem_req && !dmem_ready && state_q != ERR;
  assign hold     = freeze || state_q == ERR;
  assign jr_stall = id_jump == JMP_JR && ex_reg_write && ex_rd != 5'd0 && ex_rd == id_rs;
  assign load_use = ex_mem_read && ex_rd != 5'd0 &&
                    ((id_uses_rs && ex_rd == id_rs) || (id_uses_rt && ex_rd == id_rt));
  assign stall    = !ex_branch_taken && (jr_stall || load_use);
  assign jump     = id_jump == JMP_J || id_jump == JMP_JR;
  assign pc_en      = !hold && !stall;
  assign ifid_en    = !hold && !stall;
  assign idex_en    = !hold;
  assign exmem_en   = !hold;
  assign memwb_en   = !hold;
  assign ifid_flush = !hold && (ex_branch_taken || (!stall && jump));
  assign idex_flush = !hold && (ex_branch_taken || stall);
  assign fwd_a      = fwd_sel(ex_rs, mem_reg_write, mem_rd, wb_reg_write, wb_rd);
  assign fwd_b      = fwd_sel(ex_rt, mem_reg_write, mem_rd, wb_reg_write, wb_rd);
  assign mem_err    = mem_err_q;
  // The RUN cycle that raises the freeze is the first wait cycle, so MEM_WAIT starts at 1.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= RUN;
      wait_q    <= '0;
      mem_err_q <= 1'b0;
    end else begin
      case (state_q)
        RUN:
          if (freeze && TIMEOUT <= 1) begin
            state_q   <= ERR;
            mem_err_q <= 1'b1;
          end else if (freeze) begin
            state_q <= MEM_WAIT;
            wait_q  <= WW'(1);
          end
        MEM_WAIT:
          if (!freeze) begin
            state_q <= RUN;
            wait_q  <= '0;
          end else if (wait_q == WW'(TIMEOUT - 1)) begin
            state_q   <= ERR;
            wait_q    <= '0;
            mem_err_q <= 1'b1;
          end else wait_q <= wait_q + 1'b1;
        default: ;
      endcase
    end
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst_n(rst_n), .inc_i(!pc_en && state_q != ERR), .cnt_o(stall_cnt));
  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk(clk), .rst_n(rst_n), .inc_i(ifid_flush || idex_flush), .cnt_o(flush_cnt));
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl (TIMEOUT=4, CNT_W=4).
module tb_hazard_ctrl;
  localparam int TO = 4;
  localparam int CW = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic id_uses_rs, id_uses_rt, ex_mem_read, ex_reg_write, ex_branch_taken;
  logic mem_reg_write, dmem_req, dmem_ready, wb_reg_write;
  logic [1:0] id_jump, fwd_a, fwd_b;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, mem_err;
  logic [CW-1:0] stall_cnt, flush_cnt;
  int n_cmp = 0, n_bad = 0;
  int sc_m = 0, fc_m = 0;
  typedef struct {
    string      tag;
    logic [4:0] en;
    logic [1:0] fl;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       err;
    int         sc;
    int         fc;
  } exp_t;
  exp_t sb[$];

  hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt), .id_jump(id_jump), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .ex_branch_taken(ex_branch_taken),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .dmem_req(dmem_req),
    .dmem_ready(dmem_ready), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .pc_en(pc_en),
    .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    {id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd} = '0;
    {id_uses_rs, id_uses_rt, ex_mem_read, ex_reg_write, ex_branch_taken} = '0;
    {mem_reg_write, dmem_req, dmem_ready, wb_reg_write} = '0;
    id_jump = 2'b00;
  endtask

  // en = {pc,ifid,idex,exmem,memwb}, fl = {ifid_flush,idex_flush}
  task automatic cyc(input string tag, input logic [4:0] en, input logic [1:0] fl,
                     input logic [1:0] fa, input logic [1:0] fb, input logic err);
    exp_t e;
    sb.push_back('{tag, en, fl, fa, fb, err, sc_m, fc_m});
    @(negedge clk);
    e = sb.pop_front();
    chk({e.tag, ".en"}, {pc_en, ifid_en, idex_en, exmem_en, memwb_en}, e.en);
    chk({e.tag, ".fl"}, {ifid_flush, idex_flush}, e.fl);
    chk({e.tag, ".fa"}, fwd_a, e.fa);
    chk({e.tag, ".fb"}, fwd_b, e.fb);
    chk({e.tag, ".err"}, mem_err, e.err);
    chk({e.tag, ".sc"}, stall_cnt, e.sc);
    chk({e.tag, ".fc"}, flush_cnt, e.fc);
    if (!e.en[4] && !e.err && sc_m < 15) sc_m++;
    if (e.fl != 2'b00 && fc_m < 15) fc_m++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cyc("rst", 5'b11111, 2'b00, 2'b00, 2'b00, 1'b0);
    ex_mem_read = 1; ex_reg_write = 1; ex_rd = 8; id_rs = 8; id_uses_rs = 1;
    cyc("lu", 5'b00111, 2'b01, 2'b00, 2'b00, 1'b0);
    clr();
    cyc("lu_after", 5'b11111, 2'b00, 2'b00, 2'b00, 1'b0);
    ex_mem_read = 1; ex_rd = 8; id_rt = 8; id_rs = 3; id_uses_rs = 1;
    cyc("lu_rt_unused", 5'b11111, 2'b00, 2'b00, 2'b00, 1'b0);
    id_uses_rt = 1;
    cyc("lu_rt", 5'b00111, 2'b01, 2'b00, 2'b00, 1'b0);
    clr();
    ex_rs = 5; ex_rt = 5; mem_rd = 5; wb_rd = 5; mem_reg_write = 1; wb_reg_write = 1;
    cyc("fwd_mem", 5'b11111, 2'b00, 2'b10, 2'b10, 1'b0);
    mem_rd = 0;
    cyc("fwd_wb", 5'b11111, 2'b00, 2'b01, 2'b01, 1'b0);
    ex_rs = 0; ex_rt = 0; wb_rd = 0;
    cyc("fwd_zero", 5'b11111, 2'b00, 2'b00, 2'b00, 1'b0);
    ex_rs = 5; mem_rd = 5; ex_rt = 7; wb_rd = 7;
    cyc("fwd_mix", 5'b11111, 2'b00, 2'b10, 2'b01, 1'b0);
    clr();
    id_jump = 2'b10; id_rs = 9; ex_rd = 9; ex_reg_write = 1;
    cyc("jr_stall", 5'b00111, 2'b01, 2'b00, 2'b00, 1'b0);
    ex_branch_taken = 1;
    cyc("br_over_jr", 5'b11111, 2'b11, 2'b00, 2'b00, 1'b0);
    clr();
    id_jump = 2'b01;
    cyc("jump", 5'b11111, 2'b10, 2'b00, 2'b00, 1'b0);
    id_jump = 2'b10; ex_reg_write = 1;
    cyc("jr_r0", 5'b11111, 2'b10, 2'b00, 2'b00, 1'b0);
    clr();
    dmem_req = 1; dmem_ready = 1;
    cyc("dmem_fast", 5'b11111, 2'b00, 2'b00, 2'b00, 1'b0);
    chk("fast_nowait", dut.wait_q, 0);
    dmem_ready = 0; ex_branch_taken = 1;
    for (int i = 0; i < 3; i++) cyc($sformatf("freeze%0d", i), 5'b00000, 2'b00, 2'b00, 2'b00, 1'b0);
    dmem_ready = 1;
    cyc("release_br", 5'b11111, 2'b11, 2'b00, 2'b00, 1'b0);
    chk("wait_clr", dut.wait_q, 0);
    clr();
    cyc("after_mem", 5'b11111, 2'b00, 2'b00, 2'b00, 1'b0);
    dmem_req = 1;
    for (int i = 0; i < TO; i++) cyc($sformatf("to_wait%0d", i), 5'b00000, 2'b00, 2'b00, 2'b00, 1'b0);
    cyc("err", 5'b00000, 2'b00, 2'b00, 2'b00, 1'b1);
    clr();
    ex_branch_taken = 1;
    cyc("err_sticky", 5'b00000, 2'b00, 2'b00, 2'b00, 1'b1);
    clr();
    cyc("err_sticky2", 5'b00000, 2'b00, 2'b00, 2'b00, 1'b1);
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    sc_m = 0; fc_m = 0;
    cyc("post_rst", 5'b11111, 2'b00, 2'b00, 2'b00, 1'b0);
    chk("post_rst_wait", dut.wait_q, 0);
    dmem_req = 1;
    cyc("mw_rst0", 5'b00000, 2'b00, 2'b00, 2'b00, 1'b0);
    cyc("mw_rst1", 5'b00000, 2'b00, 2'b00, 2'b00, 1'b0);
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    sc_m = 0; fc_m = 0;
    clr();
    cyc("mw_rst_run", 5'b11111, 2'b00, 2'b00, 2'b00, 1'b0);
    chk("mw_rst_wait", dut.wait_q, 0);
    ex_mem_read = 1; ex_rd = 4; id_rs = 4; id_uses_rs = 1;
    for (int i = 0; i < 20; i++) cyc($sformatf("sat%0d", i), 5'b00111, 2'b01, 2'b00, 2'b00, 1'b0);
    clr();
    cyc("sat_end", 5'b11111, 2'b00, 2'b00, 2'b00, 1'b0);
    chk("sat_sc", stall_cnt, 15);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, got running expected done");
    $fatal(1);
  end
endmodule
